// File: rtl/seg_pkg.sv
// Shared constants and FSM encoding for the segment scan decoder.
package seg_pkg;

  localparam int NUM_DIGITS    = 8;
  localparam int DIGIT_W       = 4;
  localparam int SLOT_W        = 3;
  localparam int DWELL_DEFAULT = 4;

  typedef enum logic {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } state_t;

endpackage

// File: rtl/seg_slot_timer.sv
// Phase/slot counter that follows the display driver's digit scan.
// A load marks the current cycle as phase 0 of load_slot, so the
// registered phase resumes at 1 on the following cycle.
module seg_slot_timer
  import seg_pkg::*;
#(
  parameter int DWELL   = DWELL_DEFAULT,
  parameter int PHASE_W = $clog2(DWELL)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [SLOT_W-1:0]  load_slot,
  input  logic               enable,
  output logic [PHASE_W-1:0] phase,
  output logic [SLOT_W-1:0]  slot,
  output logic               slot_end
);

  assign slot_end = (phase == PHASE_W'(DWELL - 1));

  // Advance phase each enabled cycle; wrap into the next slot at the dwell end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
      slot  <= '0;
    end else if (load) begin
      phase <= PHASE_W'(1);
      slot  <= load_slot;
    end else if (enable) begin
      if (slot_end) begin
        phase <= '0;
        slot  <= slot + 1'b1;
      end else begin
        phase <= phase + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers the 8-digit frame being scanned out by a segment display driver.
// Locks onto the digit-index transitions, samples each slot mid-dwell and
// publishes a frame only after a complete, error-free pass over slots 0..7.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int DWELL  = DWELL_DEFAULT,
  parameter int SAMPLE = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SLOT_W-1:0]             seg_an,
  input  logic [DIGIT_W-1:0]            seg_data,
  output logic [NUM_DIGITS*DIGIT_W-1:0] output_data,
  output logic [NUM_DIGITS-1:0]         output_valid,
  output logic                          frame_valid,
  output logic                          locked,
  output logic                          sync_err
);

  localparam int PHASE_W = $clog2(DWELL);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_DIGITS - 1);

  state_t                        state_q, state_d;
  logic [SLOT_W-1:0]             an_prev;
  logic [NUM_DIGITS-1:0]         sampled, sampled_d;
  logic [NUM_DIGITS*DIGIT_W-1:0] shadow_data, shadow_data_d;
  logic [NUM_DIGITS-1:0]         shadow_valid, shadow_valid_d;
  logic [PHASE_W-1:0]            phase;
  logic [SLOT_W-1:0]             slot;
  logic                          slot_end;

  logic an_edge, in_track, hunt_lock, at_sample;
  logic sample_hit, sample_blank, sample_ok, err, frame_end, publish;

  assign an_edge      = (seg_an != an_prev);
  assign in_track     = (state_q == TRACK);
  assign hunt_lock    = !in_track && an_edge && (seg_an != '0);
  assign at_sample    = in_track && (phase == PHASE_W'(SAMPLE));
  assign sample_hit   = at_sample && (seg_an == slot);
  assign sample_blank = at_sample && (slot != '0) && (seg_an == '0);
  assign sample_ok    = sample_hit || sample_blank;
  // A transition is only legal on phase 0, i.e. exactly on a slot boundary.
  assign err          = in_track && ((an_edge && (phase != '0)) || (at_sample && !sample_ok));
  assign frame_end    = in_track && slot_end && (slot == LAST_SLOT);
  assign publish      = frame_end && !err && (sampled_d == '1);
  assign locked       = in_track;

  seg_slot_timer #(
    .DWELL   (DWELL),
    .PHASE_W (PHASE_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (hunt_lock),
    .load_slot (seg_an),
    .enable    (in_track),
    .phase     (phase),
    .slot      (slot),
    .slot_end  (slot_end)
  );

  // Merge this cycle's sample into the shadow frame so a sample on the
  // final phase of slot 7 is still included in the publish.
  always_comb begin
    sampled_d      = sampled;
    shadow_data_d  = shadow_data;
    shadow_valid_d = shadow_valid;
    if (sample_ok) begin
      sampled_d[slot]                             = 1'b1;
      shadow_valid_d[slot]                        = sample_hit;
      shadow_data_d[slot*DIGIT_W +: DIGIT_W]      = sample_hit ? seg_data : '0;
    end
  end

  // Lock state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= HUNT;
    else     state_q <= state_d;
  end

  // Lock state transitions: acquire on a nonzero index edge, drop on any sync error.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:    if (hunt_lock) state_d = TRACK;
      TRACK:   if (err)       state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end

  // Edge history, shadow frame, sampled mask and published outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_prev      <= '0;
      sampled      <= '0;
      shadow_data  <= '0;
      shadow_valid <= '0;
      output_data  <= '0;
      output_valid <= '0;
      frame_valid  <= 1'b0;
      sync_err     <= 1'b0;
    end else begin
      an_prev      <= seg_an;
      shadow_data  <= shadow_data_d;
      shadow_valid <= shadow_valid_d;
      if (hunt_lock || err || frame_end) sampled <= '0;
      else                               sampled <= sampled_d;
      frame_valid  <= publish;
      sync_err     <= err;
      if (publish) begin
        output_data  <= shadow_data_d;
        output_valid <= shadow_valid_d;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: a segment-driver stimulus source and a
// position-counting reference model of the decoder.
module tb_seg_scan_decoder;

  localparam int DWELL    = 4;
  localparam int SAMPLE   = 2;
  localparam int TIME_CNT = 3;
  localparam int FRAME    = 8 * DWELL;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  seg_an;
  logic [3:0]  seg_data;
  logic [31:0] output_data;
  logic [7:0]  output_valid;
  logic        frame_valid;
  logic        locked;
  logic        sync_err;

  seg_scan_decoder #(.DWELL(DWELL), .SAMPLE(SAMPLE)) dut (
    .clk          (clk),
    .rst          (rst),
    .seg_an       (seg_an),
    .seg_data     (seg_data),
    .output_data  (output_data),
    .output_valid (output_valid),
    .frame_valid  (frame_valid),
    .locked       (locked),
    .sync_err     (sync_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  // display driver state
  int          drv_digit = 0;
  int          drv_cnt   = 0;
  logic [31:0] drv_data  = 32'h0;
  logic [7:0]  drv_valid = 8'h01;

  // reference model state: m_pos = slot*DWELL + phase of the next cycle
  bit          m_lock;
  int          m_pos;
  logic [2:0]  m_prev;
  bit   [7:0]  m_have;
  logic [3:0]  m_sd [8];
  bit          m_sv [8];
  logic [31:0] m_od;
  logic [7:0]  m_ov;
  bit          m_fv, m_se;

  function automatic logic [42:0] dut_vec();
    return {output_data, output_valid, frame_valid, locked, sync_err};
  endfunction

  function automatic logic [42:0] m_vec();
    return {m_od, m_ov, m_fv, m_lock, m_se};
  endfunction

  task automatic model_reset();
    m_lock = 0; m_pos = 0; m_prev = 3'd0; m_have = 8'h00;
    m_od = 32'h0; m_ov = 8'h00; m_fv = 0; m_se = 0;
    for (int i = 0; i < 8; i++) begin m_sd[i] = 4'h0; m_sv[i] = 0; end
  endtask

  task automatic model_step(input logic [2:0] an, input logic [3:0] d);
    int slot, phase;
    bit ed, bad;
    m_fv = 0; m_se = 0;
    ed = (an != m_prev);
    m_prev = an;
    if (!m_lock) begin
      if (ed && an != 3'd0) begin
        m_lock = 1; m_have = 8'h00;
        m_pos = int'(an) * DWELL + 1;
      end
    end else begin
      slot  = m_pos / DWELL;
      phase = m_pos % DWELL;
      bad   = ed && (phase != 0);
      if (phase == SAMPLE) begin
        if (int'(an) == slot) begin
          m_sd[slot] = d; m_sv[slot] = 1; m_have[slot] = 1;
        end else if (slot != 0 && an == 3'd0) begin
          m_sd[slot] = 4'h0; m_sv[slot] = 0; m_have[slot] = 1;
        end else begin
          bad = 1;
        end
      end
      if (bad) begin
        m_lock = 0; m_se = 1; m_have = 8'h00;
      end else begin
        if (m_pos == FRAME - 1) begin
          if (m_have == 8'hFF) begin
            for (int i = 0; i < 8; i++) begin
              m_od[4*i +: 4] = m_sd[i];
              m_ov[i] = m_sv[i];
            end
            m_fv = 1;
          end
          m_have = 8'h00;
        end
        m_pos = (m_pos + 1) % FRAME;
      end
    end
  endtask

  // one clock: drive on negedge, step the model, settle after posedge
  task automatic cycle(input bit frc, input logic [2:0] frc_an);
    logic [2:0] a;
    logic [3:0] d;
    @(negedge clk);
    a = drv_valid[drv_digit] ? 3'(drv_digit) : 3'd0;
    d = drv_valid[drv_digit] ? drv_data[4*drv_digit +: 4] : 4'h0;
    if (frc) a = frc_an;
    seg_an = a;
    seg_data = d;
    if (rst) model_reset();
    else     model_step(a, d);
    if (drv_cnt == TIME_CNT) begin
      drv_cnt = 0;
      drv_digit = (drv_digit + 1) % 8;
    end else begin
      drv_cnt++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drv_digit = 0; drv_cnt = 0;
    model_reset();
    repeat (2) cycle(1'b0, 3'd0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drv_data = 32'h87654321; drv_valid = 8'hFF;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 3'd0);
      n_total++;
      if (dut_vec() !== 43'h0)
        $display("FAIL reset cyc=%0d dut=%h required=%h", cyc, dut_vec(), 43'h0);
      else n_pass++;
    end
    rst = 1'b0;
  endtask

  task automatic test_full_valid();
    int nfr, mfr, last;
    bit seen_lock;
    drv_data = 32'h12345678; drv_valid = 8'hFF;
    do_reset();
    nfr = 0; mfr = 0; last = -1; seen_lock = 0;
    for (int i = 0; i < 200; i++) begin
      cycle(1'b0, 3'd0);
      n_total++;
      if (dut_vec() !== m_vec())
        $display("FAIL full_cycle cyc=%0d dut=%h model=%h", cyc, dut_vec(), m_vec());
      else n_pass++;
      if (locked === 1'b1) seen_lock = 1;
      if (m_fv) mfr++;
      if (frame_valid === 1'b1) begin
        nfr++;
        n_total++;
        if (output_data !== 32'h12345678 || output_valid !== 8'hFF)
          $display("FAIL full_frame data=%h valid=%h required=12345678/ff", output_data, output_valid);
        else n_pass++;
        if (last >= 0) begin
          n_total++;
          if (cyc - last != FRAME)
            $display("FAIL full_period got=%0d required=%0d", cyc - last, FRAME);
          else n_pass++;
        end
        last = cyc;
      end
    end
    n_total++;
    if (!seen_lock || nfr < 4 || nfr != mfr)
      $display("FAIL full_count lock=%0d frames=%0d model_frames=%0d", seen_lock, nfr, mfr);
    else n_pass++;
  endtask

  task automatic test_partial_mask();
    int nerr;
    drv_data = 32'hDEADBEEF; drv_valid = 8'h0F;
    do_reset();
    nerr = 0;
    for (int i = 0; i < 200; i++) begin
      cycle(1'b0, 3'd0);
      n_total++;
      if (dut_vec() !== m_vec())
        $display("FAIL partial_cycle cyc=%0d dut=%h model=%h", cyc, dut_vec(), m_vec());
      else n_pass++;
      if (sync_err !== 1'b0) nerr++;
    end
    n_total++;
    if (output_data !== 32'h0000BEEF || output_valid !== 8'h0F || nerr != 0)
      $display("FAIL partial_frame data=%h valid=%h errs=%0d required=0000beef/0f/0",
               output_data, output_valid, nerr);
    else n_pass++;
  endtask

  task automatic test_slot7_lock();
    int lock_cyc, fv_cyc;
    drv_data = 32'hA0000003; drv_valid = 8'h81;
    do_reset();
    lock_cyc = -1; fv_cyc = -1;
    for (int i = 0; i < 200; i++) begin
      cycle(1'b0, 3'd0);
      n_total++;
      if (dut_vec() !== m_vec())
        $display("FAIL slot7_cycle cyc=%0d dut=%h model=%h", cyc, dut_vec(), m_vec());
      else n_pass++;
      if (locked === 1'b1 && lock_cyc < 0) lock_cyc = cyc;
      if (frame_valid === 1'b1 && fv_cyc < 0) begin
        fv_cyc = cyc;
        n_total++;
        if (output_data !== 32'hA0000003 || output_valid !== 8'h81)
          $display("FAIL slot7_frame data=%h valid=%h required=a0000003/81", output_data, output_valid);
        else n_pass++;
      end
    end
    n_total++;
    if (lock_cyc < 0 || fv_cyc < 0 || fv_cyc - lock_cyc < FRAME)
      $display("FAIL slot7_latency lock=%0d first_frame=%0d min_gap=%0d", lock_cyc, fv_cyc, FRAME);
    else n_pass++;
  endtask

  task automatic test_hunt_only();
    int bad;
    drv_data = $urandom; drv_valid = 8'h01;
    do_reset();
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      cycle(1'b0, 3'd0);
      n_total++;
      if (dut_vec() !== m_vec())
        $display("FAIL hunt_cycle cyc=%0d dut=%h model=%h", cyc, dut_vec(), m_vec());
      else n_pass++;
      if (locked !== 1'b0 || frame_valid !== 1'b0) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL hunt_idle bad_cycles=%0d required=0", bad);
    else n_pass++;
  endtask

  task automatic test_glitch();
    int st, nerr;
    bit frc;
    drv_data = 32'h12345678; drv_valid = 8'hFF;
    do_reset();
    st = 0; nerr = 0;
    for (int i = 0; i < 300; i++) begin
      frc = (st == 1 && drv_digit == 2 && drv_cnt == 1);
      cycle(frc, 3'd5);
      n_total++;
      if (dut_vec() !== m_vec())
        $display("FAIL glitch_cycle cyc=%0d dut=%h model=%h", cyc, dut_vec(), m_vec());
      else n_pass++;
      if (sync_err === 1'b1) nerr++;
      if (frc) begin
        n_total++;
        if (sync_err !== 1'b1 || locked !== 1'b0)
          $display("FAIL glitch_err sync_err=%b locked=%b required=1/0", sync_err, locked);
        else n_pass++;
        st = 2;
      end else if (st == 2) begin
        n_total++;
        if (frame_valid === 1'b1) begin
          if (output_data !== 32'h9ABCDEF1)
            $display("FAIL glitch_relock data=%h required=9abcdef1", output_data);
          else n_pass++;
          st = 3;
        end else begin
          if (output_data !== 32'h12345678 || output_valid !== 8'hFF)
            $display("FAIL glitch_hold data=%h valid=%h required=12345678/ff", output_data, output_valid);
          else n_pass++;
        end
      end
      if (st == 0 && frame_valid === 1'b1) begin
        st = 1;
        drv_data = 32'h9ABCDEF1;
      end
    end
    n_total++;
    if (st != 3 || nerr < 1)
      $display("FAIL glitch_done stage=%0d errs=%0d required=3/>=1", st, nerr);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int first;
    drv_data = 32'h12345678; drv_valid = 8'hFF;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      cycle(1'b0, 3'd0);
      n_total++;
      if (dut_vec() !== m_vec())
        $display("FAIL rstmid_pre cyc=%0d dut=%h model=%h", cyc, dut_vec(), m_vec());
      else n_pass++;
    end
    rst = 1'b1;
    #1;
    n_total++;
    if (dut_vec() !== 43'h0)
      $display("FAIL rstmid_async dut=%h required=%h", dut_vec(), 43'h0);
    else n_pass++;
    model_reset();
    repeat (2) cycle(1'b0, 3'd0);
    rst = 1'b0;
    first = -1;
    for (int i = 0; i < 200; i++) begin
      cycle(1'b0, 3'd0);
      n_total++;
      if (dut_vec() !== m_vec())
        $display("FAIL rstmid_post cyc=%0d dut=%h model=%h", cyc, dut_vec(), m_vec());
      else n_pass++;
      if (frame_valid === 1'b1 && first < 0) begin
        first = i + 1;
        n_total++;
        if (output_data !== 32'h12345678)
          $display("FAIL rstmid_frame data=%h required=12345678", output_data);
        else n_pass++;
      end
    end
    n_total++;
    if (first < FRAME)
      $display("FAIL rstmid_latency first_frame=%0d required>=%0d", first, FRAME);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit frc;
    logic [2:0] fan;
    for (int r = 0; r < 6; r++) begin
      drv_data  = $urandom;
      drv_valid = 8'($urandom) | 8'h01;
      for (int i = 0; i < 150; i++) begin
        frc = ($urandom_range(0, 59) == 0);
        fan = 3'($urandom_range(0, 7));
        cycle(frc, fan);
        n_total++;
        if (dut_vec() !== m_vec())
          $display("FAIL random_cycle round=%0d cyc=%0d dut=%h model=%h", r, cyc, dut_vec(), m_vec());
        else n_pass++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    seg_an = 3'd0;
    seg_data = 4'h0;
    model_reset();
    test_reset();
    test_full_valid();
    test_partial_mask();
    test_slot7_lock();
    test_hunt_only();
    test_glitch();
    test_reset_mid_frame();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter DWELL, default 4, SHALL set the cycles per digit slot and SHALL be 2 or more.
REQ-002 Parameter SAMPLE, default 2, SHALL set the in-slot phase at which a slot is sampled, range 1..DWELL-1.
REQ-003 clk  in  1  single clock, all state on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 seg_an  in  3  scanned digit index from the Segment display driver, same clock domain.
REQ-006 seg_data  in  4  scanned digit nibble.
REQ-007 output_data  out  32  last published frame, nibble i at bits [4i+3:4i].
REQ-008 output_valid  out  8  last published digit-valid mask.
REQ-009 frame_valid  out  1  one-cycle pulse when output_data/output_valid update.
REQ-010 locked  out  1  high while in TRACK.
REQ-011 sync_err  out  1  one-cycle pulse on loss of lock.

Function
REQ-012 The block SHALL register seg_an each cycle as an_prev; an "edge" SHALL be seg_an != an_prev.
REQ-013 The FSM SHALL have two states: HUNT (locked=0) and TRACK (locked=1).
REQ-014 In HUNT, an edge to a nonzero value k SHALL set slot=k, phase=0, clear the sampled mask, and enter TRACK.
REQ-015 In HUNT, edges to 0 SHALL be ignored.
REQ-016 With valid mask 0x01, seg_an stays 0, so the block SHALL stay in HUNT indefinitely with no frame_valid.
REQ-017 In TRACK, phase SHALL increment each cycle; at phase DWELL-1 it SHALL wrap to 0 and slot SHALL increment modulo 8.
REQ-018 In TRACK, any edge while phase != 0 (phase counted before the update) SHALL be a sync error.
REQ-019 At phase == SAMPLE, the block SHALL capture slot as follows:
- seg_an == slot: shadow_valid[slot]=1, shadow nibble=seg_data.
- slot != 0 and seg_an == 0: shadow_valid[slot]=0, shadow nibble=0.
- any other case: sync error.
REQ-020 Each successful sample SHALL set sampled[slot].
REQ-021 At phase DWELL-1 of slot 7, if sampled == 8'hFF, the block SHALL copy the shadow to output_data/output_valid and pulse frame_valid in the next cycle, then clear sampled.
REQ-022 At that same boundary, if sampled != 8'hFF (partial first frame), the block SHALL clear sampled without publishing.
REQ-023 A sync error SHALL pulse sync_err for one cycle, return to HUNT, clear sampled, and hold the published outputs.
REQ-024 Publish latency SHALL be 1 cycle after the final phase of slot 7.
REQ-025 output_valid[0] SHALL be 1 in every published frame.
REQ-026 If an edge and a slot boundary fall in the same cycle, the edge SHALL take phase 0 of the new slot and SHALL NOT be an error.
REQ-027 If the first lock lands mid-slot (e.g. just after reset), the resulting error and relock SHALL be the required behaviour; no special case is added.

Reset
REQ-028 While rst is high, the block SHALL hold:
- state=HUNT; an_prev, slot, phase, sampled, shadow = 0.
- output_data=0, output_valid=0, frame_valid=0, locked=0, sync_err=0.
REQ-029 Reset mid-frame SHALL discard the partial frame, and no frame_valid SHALL occur until a full slot 0..7 pass after relock.

Structure
REQ-030 Shared package seg_pkg SHALL hold NUM_DIGITS=8, DIGIT_W=4, the default DWELL, and the HUNT/TRACK encoding.
REQ-031 Phase/slot counting SHALL be a sub-module seg_slot_timer (inputs: load, load_slot, enable; outputs: phase, slot, slot_end).
REQ-032 The RTL SHALL fit in 120-400 lines.

Verification
REQ-033 Segment driver (TIME_CNT=3), data 0x12345678, valid 0xFF -> locked=1, then frame_valid, output_data=0x12345678, output_valid=0xFF, repeating every 32 cycles.
REQ-034 data 0xDEADBEEF, valid 0x0F -> output_data=0x0000BEEF, output_valid=0x0F, no sync_err.
REQ-035 data 0xA0000003, valid 0x81 -> lock on slot 7; first publish only after a complete 0..7 pass gives 0xA0000003 / 0x81.
REQ-036 valid 0x01 -> locked=0 and frame_valid=0 for 1000 cycles.
REQ-037 Force seg_an=5 for one cycle mid-slot-2 -> sync_err pulse, locked=0, outputs held; relock gives a correct next frame.
REQ-038 Assert rst mid-frame -> all outputs 0 immediately; after release, first frame_valid only after a full frame.
